mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 21 ++
 rtl/mem_responder.sv | 146 ++++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, depth, FSM state type and counter helper for the memory responder.
package mem_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 16;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_CLEAR
    } state_t;

    // Statistics counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/mem_array.sv
// 32 x 8 storage: one synchronous write port, one combinational read port, no reset.
module mem_array
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder with programmable wait states, a 32-cycle clear
// sweep and saturating read/write statistics.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        wait_cnt_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              ack_reg;
    logic              busy_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [CNT_W-1:0]  rd_count_reg;
    logic [CNT_W-1:0]  wr_count_reg;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // The clear sweep owns the write port; otherwise a write commits as ACK ends.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg;
        mem_wdata = wdata_reg;
        if (state_reg == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_reg;
            mem_wdata = '0;
        end else if (state_reg == ST_ACK && we_reg) begin
            mem_we = 1'b1;
        end
        // With no wait states ACK follows IDLE directly, so read the live address.
        mem_raddr = (state_reg == ST_IDLE) ? addr : addr_reg;
    end

    mem_array u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
            clr_ptr_reg  <= '0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            rdata_reg    <= '0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr) begin
                        state_reg   <= ST_CLEAR;
                        busy_reg    <= 1'b1;
                        clr_ptr_reg <= '0;
                    end else if (req) begin
                        we_reg    <= we;
                        addr_reg  <= addr;
                        wdata_reg <= wdata;
                        busy_reg  <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end else begin
                            state_reg <= ST_ACK;
                            ack_reg   <= 1'b1;
                            if (!we) begin
                                rdata_reg <= mem_rdata;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
                        if (!we_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    if (we_reg) begin
                        wr_count_reg <= sat_inc(wr_count_reg);
                    end else begin
                        rd_count_reg <= sat_inc(rd_count_reg);
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr_reg == LAST_ADDR) begin
                        state_reg   <= ST_IDLE;
                        busy_reg    <= 1'b0;
                        clr_ptr_reg <= '0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = ack_reg;
    assign busy     = busy_reg;
    assign rdata    = rdata_reg;
    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder without wait states, one with three; a select
// line steers stimulus and observation to one of them.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        clr = 1'b0;
    logic        sel = 1'b0;

    logic        ack0, busy0, ack3, busy3;
    logic [7:0]  rdata0, rdata3;
    logic [15:0] rdc0, wrc0, rdc3, wrc3;
    logic        req0, req3, clr0, clr3;

    int checks = 0;
    int errors = 0;

    assign req0 = req & ~sel;
    assign clr0 = clr & ~sel;
    assign req3 = req & sel;
    assign clr3 = clr & sel;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .clr(clr0), .ack(ack0), .rdata(rdata0), .busy(busy0),
        .rd_count(rdc0), .wr_count(wrc0)
    );

    mem_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .clr(clr3), .ack(ack3), .rdata(rdata3), .busy(busy3),
        .rd_count(rdc3), .wr_count(wrc3)
    );

    logic        ack_s, busy_s;
    logic [7:0]  rdata_s;
    logic [15:0] rdc_s, wrc_s;
    assign ack_s   = sel ? ack3 : ack0;
    assign busy_s  = sel ? busy3 : busy0;
    assign rdata_s = sel ? rdata3 : rdata0;
    assign rdc_s   = sel ? rdc3 : rdc0;
    assign wrc_s   = sel ? wrc3 : wrc0;

    typedef struct {
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction; addr/wdata switch to a2/d2 right after req is sampled.
    task automatic access(input logic w, input logic [4:0] a, input logic [7:0] d,
                          input logic [4:0] a2, input logic [7:0] d2, output logic [7:0] rd);
        int  k;
        bit  seen;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; addr = a2; wdata = d2;
        k = 1; seen = 1'b0;
        while (!seen && k < 40) begin
            if (ack_s) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
        else chk("ack_latency", k, sel ? 32'd4 : 32'd1);
        rd = rdata_s;
        @(posedge clk); #1;
        chk("ack_one_cycle", ack_s, 32'd0);
        chk("busy_after_ack", busy_s, 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] rd;
        access(1'b1, a, d, a, d, rd);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        access(1'b0, a, 8'h00, a, 8'h00, rd);
        chk($sformatf("%s_addr%0d", name, a), rd, exp);
    endtask

    // Pulse clr (optionally with req) and return busy length and whether ack appeared.
    task automatic do_clear(input logic with_req, output int n, output bit ack_seen);
        clr = 1'b1; req = with_req; we = 1'b1; addr = 5'd7; wdata = 8'h77;
        @(posedge clk); #1;
        clr = 1'b0; req = 1'b0;
        n = 0; ack_seen = 1'b0;
        while (busy_s && n < 100) begin
            if (ack_s) ack_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t       tbl[12];
        logic [7:0] rd;
        int         n;
        bit         ack_seen;
        logic [15:0] wr_before;

        tbl[0]  = '{1'b1, 5'd5,  8'hA5, 8'h1F};
        tbl[1]  = '{1'b0, 5'd5,  8'h00, 8'hA5};
        tbl[2]  = '{1'b1, 5'd31, 8'hFF, 8'hA5};
        tbl[3]  = '{1'b0, 5'd31, 8'h00, 8'hFF};
        tbl[4]  = '{1'b0, 5'd0,  8'h00, 8'h00};
        tbl[5]  = '{1'b1, 5'd0,  8'h3C, 8'h00};
        tbl[6]  = '{1'b0, 5'd0,  8'h00, 8'h3C};
        tbl[7]  = '{1'b0, 5'd5,  8'h00, 8'hA5};
        tbl[8]  = '{1'b0, 5'd17, 8'h00, 8'h11};
        tbl[9]  = '{1'b1, 5'd17, 8'hC3, 8'h11};
        tbl[10] = '{1'b0, 5'd17, 8'h00, 8'hC3};
        tbl[11] = '{1'b0, 5'd30, 8'h00, 8'h1E};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack0", ack0, 0);     chk("rst_busy0", busy0, 0);
        chk("rst_rdata0", rdata0, 0); chk("rst_rdc0", rdc0, 0);
        chk("rst_wrc0", wrc0, 0);     chk("rst_busy3", busy3, 0);
        chk("rst_rdata3", rdata3, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clear sweep, then confirm every location reads zero.
        do_clear(1'b0, n, ack_seen);
        chk("clear_busy_cycles", n, 32);
        chk("clear_no_ack", ack_seen, 0);
        for (int i = 0; i < 32; i++) rd_chk("clear_read", 5'(i), 8'h00);

        // Data equals address across the whole array.
        pulse_rst();
        for (int i = 0; i < 32; i++) wr(5'(i), 8'(i));
        for (int i = 0; i < 32; i++) rd_chk("data_eq_addr", 5'(i), 8'(i));
        chk("wr_count_32", wrc_s, 16'd32);
        chk("rd_count_32", rdc_s, 16'd32);

        // Table: writes expect rdata to hold the previous read value.
        for (int i = 0; i < 12; i++) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].a, tbl[i].d, rd);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
            $display("vec%0d we=%0d addr=%0d wdata=0x%02h rdata=0x%02h", i, tbl[i].w,
                     tbl[i].a, tbl[i].d, rd);
        end

        // clr and req together: clear wins, no ack, write not counted.
        wr_before = wrc_s;
        do_clear(1'b1, n, ack_seen);
        chk("prio_busy_cycles", n, 32);
        chk("prio_no_ack", ack_seen, 0);
        chk("prio_wr_count", wrc_s, wr_before);
        rd_chk("prio_read", 5'd7, 8'h00);

        // Reset in clear cycle 10: 0-9 cleared, 10-31 untouched.
        for (int i = 0; i < 32; i++) wr(5'(i), 8'(8'h80 | i));
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midclear_busy", busy0, 0);
        chk("midclear_rdata", rdata0, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++)
            rd_chk("midclear_read", 5'(i), (i < 10) ? 8'h00 : 8'(8'h80 | i));

        // Write counter saturation.
        force dut0.wr_count_reg = 16'hFFFE;
        #1;
        release dut0.wr_count_reg;
        wr(5'd1, 8'h01);
        chk("sat_first", wrc_s, 16'hFFFF);
        wr(5'd2, 8'h02);
        wr(5'd3, 8'h03);
        chk("sat_third", wrc_s, 16'hFFFF);

        // Three wait states; addr/wdata changes during WAIT are ignored.
        sel = 1'b1;
        wr(5'd3, 8'h33);
        wr(5'd9, 8'h99);
        access(1'b0, 5'd3, 8'h00, 5'd9, 8'h00, rd);
        chk("ws3_read_latched_addr", rd, 8'h33);
        access(1'b1, 5'd4, 8'h44, 5'd9, 8'hEE, rd);
        rd_chk("ws3_read", 5'd4, 8'h44);
        rd_chk("ws3_read", 5'd9, 8'h99);
        chk("ws3_rd_count", rdc_s, 16'd3);
        chk("ws3_wr_count", wrc_s, 16'd3);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
